uart_console_tx: RTL

Memory-mapped UART transmitter that sits on the phoeniX data memory interface as a responder at the console address. It turns the core's character stores, which firmware `printf` issues to `0x1000_0000`, into an 8N1 serial stream on a single output pin. A small FIFO decouples single-cycle core stores from the much slower bit timing, so the core never stalls. A status register lets firmware poll for space and detect overflow.

---
 rtl/uart_console_tx_pkg.sv | 37 +++
 rtl/uart_console_tx_if.sv | 10 +
 rtl/uart_console_tx_sync_fifo.sv | 51 +++++
 rtl/uart_console_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_console_tx_pkg.sv
// rtl/uart_console_tx_pkg.sv - shared bus encodings, register map and FSM states for the console UART
package uart_console_tx_pkg;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [2:0] UART_TXDATA = 3'd0;
  localparam logic [2:0] UART_STATUS = 3'd4;

  localparam int STATUS_ACTIVE_BIT   = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_EMPTY_BIT    = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;
  localparam int STATUS_COUNT_LSB    = 8;
  localparam int STATUS_COUNT_W      = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic active, input logic full,
                                              input logic empty, input logic overflow,
                                              input logic [STATUS_COUNT_W-1:0] count);
    status_word = 32'h0;
    status_word[STATUS_ACTIVE_BIT]   = active;
    status_word[STATUS_FULL_BIT]     = full;
    status_word[STATUS_EMPTY_BIT]    = empty;
    status_word[STATUS_OVERFLOW_BIT] = overflow;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
  endfunction

endpackage

// File: rtl/uart_console_tx_if.sv
// rtl/uart_console_tx_if.sv - data memory interface control signals seen by the console responder
interface uart_console_tx_if;
  logic        enable;
  logic        state;
  logic [31:0] address;
  logic [3:0]  frame_mask;

  modport master (output enable, output state, output address, output frame_mask);
  modport slave  (input enable, input state, input address, input frame_mask);
endinterface

// File: rtl/uart_console_tx_sync_fifo.sv
// rtl/uart_console_tx_sync_fifo.sv - single-clock FIFO; full is judged before any same-edge pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_console_tx.sv
// rtl/uart_console_tx.sv - memory-mapped 8N1 console transmitter with TX FIFO and status register
module uart_console_tx
  import uart_console_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter int          CLK_DIV      = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_console_tx_if.slave      data_memory_interface,
  inout  wire  [31:0]           data_memory_interface_data,
  output logic                  uart_tx,
  output logic                  tx_busy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);

  tx_state_e         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [7:0]        shift, shift_next;
  logic              tx_next;
  logic              baud_done;
  logic              overflow;

  logic              sel, bus_read, bus_write;
  logic              is_status;
  logic              push_req, status_clear, push_ok;
  logic [31:0]       bus_wdata, rdata;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_bits;

  assign bus_wdata = data_memory_interface_data;
  assign sel       = (data_memory_interface.enable == ENABLE) &&
                     (data_memory_interface.address[31:3] == BASE_ADDRESS[31:3]);
  assign is_status = (data_memory_interface.address[2] == UART_STATUS[2]);
  assign bus_read  = sel && (data_memory_interface.state == READ);
  assign bus_write = sel && (data_memory_interface.state == WRITE) &&
                     data_memory_interface.frame_mask[3];

  assign push_req     = bus_write && (data_memory_interface.address[2] == UART_TXDATA[2]);
  assign status_clear = bus_write && is_status && bus_wdata[STATUS_OVERFLOW_BIT];
  assign push_ok      = push_req && !fifo_full;

  assign unused_bits = ^{data_memory_interface.address[1:0],
                         data_memory_interface.frame_mask[2:0], bus_wdata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (bus_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rdata = 32'h0;
    if (is_status) begin
      rdata = status_word(state != TX_IDLE, fifo_full, fifo_empty, overflow,
                          STATUS_COUNT_W'(fifo_count));
    end
  end

  assign data_memory_interface_data = bus_read ? rdata : 32'bz;

  assign baud_done = (baud_cnt == BAUD_W'(CLK_DIV - 1));

  // STOP reloads straight into START when more bytes wait, so frames abut.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift;
    fifo_pop   = 1'b0;
    tx_next    = 1'b1;
    case (state)
      TX_IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          bit_next   = 3'd0;
          state_next = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_cnt == 3'd7) state_next = TX_STOP;
          else                 bit_next   = bit_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            bit_next   = 3'd0;
            state_next = TX_START;
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
    case (state_next)
      TX_START: tx_next = 1'b0;
      TX_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset == ENABLE) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      uart_tx  <= tx_next;
      tx_busy  <= (state_next != TX_IDLE) || push_ok;
      // A new overflow beats a same-edge clear.
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (status_clear)     overflow <= 1'b0;
    end
  end

endmodule
